// File: rtl/eightbit_search_if.sv
// Search initiator <-> comparator/controller bundle: start request, comparator flags, probe and results.
// No backpressure: start is a pulse, and the comparator answers combinationally in the same cycle.
interface eightbit_search_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             eq;
  logic             lt;
  logic             gt;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic             found;
  logic             error;
  logic [WIDTH-1:0] result;
  logic [3:0]       steps;

  modport master (
    input  start, eq, lt, gt,
    output guess, busy, done, found, error, result, steps
  );

  modport slave (
    output start, eq, lt, gt,
    input  guess, busy, done, found, error, result, steps
  );
endinterface

// File: rtl/eightbit_search.sv
// Binary search of a hidden comparator operand; one compare per cycle, done one cycle after the final compare.
// No backpressure: start is ignored while busy or done, and requests are not queued.
module eightbit_search #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  eightbit_search_if.master bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] FIRST   = MAX_VAL >> 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lo, hi, lo_nxt, hi_nxt, mid_nxt;
  logic [WIDTH:0]   sum_nxt;
  logic [WIDTH-1:0] guess_q, result_q;
  logic [3:0]       steps_q;
  logic             found_q, error_q;
  logic             hit, bad;

  // Narrowed bounds and next probe; the sum carries an extra bit so 255+255 cannot wrap.
  always_comb begin
    lo_nxt = lo;
    hi_nxt = hi;
    hit    = 1'b0;
    bad    = 1'b0;
    case ({bus.eq, bus.lt, bus.gt})
      3'b100: hit = 1'b1;
      3'b010: begin
        if (guess_q == MAX_VAL) bad = 1'b1;
        else                    lo_nxt = guess_q + ONE;
      end
      3'b001: begin
        if (guess_q == '0) bad = 1'b1;
        else               hi_nxt = guess_q - ONE;
      end
      default: bad = 1'b1;
    endcase
    if (!hit && !bad && (lo_nxt > hi_nxt)) bad = 1'b1;
    sum_nxt = {1'b0, lo_nxt} + {1'b0, hi_nxt};
    mid_nxt = sum_nxt[WIDTH:1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SEARCH;
      SEARCH:  if (hit || bad) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == SEARCH);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo       <= '0;
      hi       <= '0;
      guess_q  <= '0;
      result_q <= '0;
      steps_q  <= '0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            lo       <= '0;
            hi       <= MAX_VAL;
            guess_q  <= FIRST;
            result_q <= '0;
            steps_q  <= '0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
          end
        end
        SEARCH: begin
          steps_q <= steps_q + 4'd1;
          if (hit) begin
            result_q <= guess_q;
            found_q  <= 1'b1;
          end else if (bad) begin
            result_q <= '0;
            found_q  <= 1'b0;
            error_q  <= 1'b1;
          end else begin
            lo      <= lo_nxt;
            hi      <= hi_nxt;
            guess_q <= mid_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.guess  = guess_q;
  assign bus.result = result_q;
  assign bus.steps  = steps_q;
  assign bus.found  = found_q;
  assign bus.error  = error_q;

endmodule

// File: tb/tb_eightbit_search.sv
// Bench for eightbit_search: behavioural comparator, expected-result scoreboard and a negedge monitor.
module tb_eightbit_search;

  typedef struct packed {
    logic       found;
    logic       error;
    logic [7:0] result;
    logic [3:0] steps;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] target;
  logic inject;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t       exp_q[$];
  logic [7:0] guess_q[$];

  always #5 clk = ~clk;

  eightbit_search_if #(.WIDTH(8)) bus ();

  eightbit_search #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Comparator facing the hidden target; inject forces the illegal eq+lt pair.
  always_comb begin
    if (inject) begin
      bus.eq = 1'b1;
      bus.lt = 1'b1;
      bus.gt = 1'b0;
    end else begin
      bus.eq = (bus.guess == target);
      bus.lt = (bus.guess <  target);
      bus.gt = (bus.guess >  target);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.busy && guess_q.size() > 0) check("guess", bus.guess, guess_q.pop_front());
      if (bus.done) begin
        check("busy with done", bus.busy, 0);
        if (exp_q.size() == 0) begin
          check("unexpected done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("found",  bus.found,  e.found);
          check("error",  bus.error,  e.error);
          check("result", bus.result, e.result);
          check("steps",  bus.steps,  e.steps);
        end
      end
    end
  end

  task automatic launch(input logic [7:0] t);
    target = t;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check("busy after start", bus.busy, 1);
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL %s: done not seen within 40 cycles", name);
    end else begin
      @(negedge clk);
      @(posedge clk);
      #1;
      check({name, " done one cycle"}, bus.done, 0);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " guess"},  bus.guess,  0);
    check({name, " busy"},   bus.busy,   0);
    check({name, " done"},   bus.done,   0);
    check({name, " found"},  bus.found,  0);
    check({name, " error"},  bus.error,  0);
    check({name, " result"}, bus.result, 0);
    check({name, " steps"},  bus.steps,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    inject    = 1'b0;
    target    = 8'd0;
    #12;
    check_all_zero("reset");
    @(negedge clk) reset = 1'b0;

    // Target at the first midpoint
    guess_q.push_back(8'd127);
    exp_q.push_back('{1'b1, 1'b0, 8'd127, 4'd1});
    launch(8'd127);
    wait_done("t127");

    // Lower edge
    foreach (guess_q[i]) ;
    guess_q = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0};
    exp_q.push_back('{1'b1, 1'b0, 8'd0, 4'd8});
    launch(8'd0);
    wait_done("t0");

    // Upper edge, exercises the wide midpoint sum
    guess_q = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
    exp_q.push_back('{1'b1, 1'b0, 8'd255, 4'd9});
    launch(8'd255);
    wait_done("t255");

    // Illegal flags on the second compare
    exp_q.push_back('{1'b0, 1'b1, 8'd0, 4'd2});
    launch(8'd200);
    @(posedge clk);
    #1;
    check("t4 second guess", bus.guess, 191);
    inject = 1'b1;
    wait_done("t_bad_flags");
    inject = 1'b0;

    // Reset in the middle of a search
    launch(8'd200);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t5 third guess", bus.guess, 223);
    reset = 1'b1;
    #1;
    check_all_zero("mid reset");
    @(negedge clk) reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t5 idle after reset", bus.busy, 0);
    exp_q.push_back('{1'b1, 1'b0, 8'd42, 4'd8});
    launch(8'd42);
    wait_done("t42");

    // Start while busy is ignored
    exp_q.push_back('{1'b1, 1'b0, 8'd5, 4'd7});
    launch(8'd5);
    repeat (2) @(negedge clk);
    check("t6 busy before restart", bus.busy, 1);
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    wait_done("t5");
    repeat (3) @(negedge clk);
    check("t6 no second search", bus.busy, 0);

    exp_q.push_back('{1'b1, 1'b0, 8'd128, 4'd8});
    launch(8'd128);
    wait_done("t128");

    repeat (3) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    check("guess queue drained", guess_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
